// File: rtl/microfono_i2s_rx.sv
// microfono_i2s_rx
// I2S master receiver for the PCM microphone path. Generates bclk/rlclk from
// clk, samples sdata on every bclk rising event and assembles MSB-first words.
//
// Ports:
//   clk    in   system clock, all logic on its rising edge
//   reset  in   asynchronous active-low reset
//   enable in   1 = run bclk/rlclk and capture, 0 = idle (state cleared)
//   sdata  in   microphone serial data, sampled at bclk rising events
//   bclk   out  bit clock, period 2*CLK_DIV clk
//   rlclk  out  word select (0 left, 1 right), one-bit lead as in I2S
//   sregr  out  last completed word, MSB = first bit received
//   ch     out  slot of the word in sregr (0 left, 1 right)
//   done   out  one-clk pulse when sregr/ch have just been updated
//
// Build option:
//   MIC_STEREO_EN  defined   -> left and right words are delivered
//                  undefined -> only left words; right slot is clocked but
//                               not stored, ch stays 0
module microfono_i2s_rx #(
  parameter int unsigned CLK_DIV = 4,   // clk cycles per bclk half-period, 1..255
  parameter int unsigned WIDTH   = 16   // bits per slot
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sdata,
  output logic             bclk,
  output logic             rlclk,
  output logic [WIDTH-1:0] sregr,
  output logic             ch,
  output logic             done
);

  localparam int unsigned     BW         = $clog2(2 * WIDTH);
  localparam logic [7:0]      DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0]   LEFT_LAST  = BW'(WIDTH - 1);
  localparam logic [BW-1:0]   RIGHT_1ST  = BW'(WIDTH);
  localparam logic [BW-1:0]   RIGHT_LAST = BW'(2 * WIDTH - 1);
  localparam logic [BW-1:0]   RL_HI_LAST = BW'(2 * WIDTH - 2);

  logic [7:0]       divcnt;
  logic [BW-1:0]    bitcnt;
  logic [BW-1:0]    bitcnt_nxt;
  logic [WIDTH-1:0] shreg;
  logic             pend;       // word assembled at the last rising event
  logic             pend_ch;
  logic             term;
  logic             rise_ev;
  logic             fall_ev;
  logic             slot_right;
  logic             rl_nxt;
  logic             capture_en;
  logic             complete;

  // bclk edges are decoded from the divider terminal count; nothing runs on bclk.
  always_comb begin
    term       = enable && (divcnt == DIV_LAST);
    rise_ev    = term && !bclk;
    fall_ev    = term && bclk;
    slot_right = (bitcnt >= RIGHT_1ST);
    bitcnt_nxt = (bitcnt == RIGHT_LAST) ? '0 : bitcnt + BW'(1);
    // rlclk leads the slot by one bit: it flips during the last bit of the
    // previous slot, so it is decoded from the counter value being entered.
    rl_nxt     = (bitcnt_nxt >= LEFT_LAST) && (bitcnt_nxt <= RL_HI_LAST);
`ifdef MIC_STEREO_EN
    capture_en = 1'b1;
    complete   = (bitcnt == LEFT_LAST) || (bitcnt == RIGHT_LAST);
`else
    capture_en = !slot_right;
    complete   = (bitcnt == LEFT_LAST);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divcnt  <= '0;
      bitcnt  <= '0;
      shreg   <= '0;
      pend    <= 1'b0;
      pend_ch <= 1'b0;
      bclk    <= 1'b0;
      rlclk   <= 1'b0;
      sregr   <= '0;
      ch      <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;

      // A word completed on the previous edge is delivered even if enable
      // drops on this edge; the enable-low clear below only hits the shifter.
      if (pend) begin
        sregr <= shreg;
        ch    <= pend_ch;
        done  <= 1'b1;
        pend  <= 1'b0;
      end

      if (!enable) begin
        divcnt <= '0;
        bitcnt <= '0;
        shreg  <= '0;
        bclk   <= 1'b0;
        rlclk  <= 1'b0;
      end else begin
        if (term) begin
          divcnt <= '0;
          bclk   <= ~bclk;
        end else begin
          divcnt <= divcnt + 8'd1;
        end

        if (rise_ev && capture_en) begin
          shreg <= {shreg[WIDTH-2:0], sdata};
          if (complete) begin
            pend    <= 1'b1;
            pend_ch <= slot_right;
          end
        end

        if (fall_ev) begin
          bitcnt <= bitcnt_nxt;
          rlclk  <= rl_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_microfono_i2s_rx.sv
// Testbench for microfono_i2s_rx: two instances (CLK_DIV=4 and CLK_DIV=1),
// each fed by a microphone model that shifts {L,R} frames MSB-first and
// advances one bit on every falling bclk.
module tb_microfono_i2s_rx;

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       en    = 2'b00;
  logic [1:0]       sd    = 2'b00;
  logic [1:0]       bc;
  logic [1:0]       rl;
  logic [1:0]       chw;
  logic [1:0]       dn;
  logic [1:0][15:0] sr;

  logic [31:0]  tx [2][16];
  int unsigned  idx [2] = '{0, 0};
  int unsigned  fi  [2] = '{0, 0};
  logic [1:0]   pb = 2'b00;
  int unsigned  dcnt [2] = '{0, 0};
  logic [15:0]  rxw [2][64];
  logic         rxc [2][64];
  int unsigned  cyc = 0;
  int unsigned  n_checks = 0;
  int unsigned  n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  microfono_i2s_rx #(.CLK_DIV(4), .WIDTH(16)) u_dut4 (
    .clk(clk), .reset(reset), .enable(en[0]), .sdata(sd[0]),
    .bclk(bc[0]), .rlclk(rl[0]), .sregr(sr[0]), .ch(chw[0]), .done(dn[0])
  );

  microfono_i2s_rx #(.CLK_DIV(1), .WIDTH(16)) u_dut1 (
    .clk(clk), .reset(reset), .enable(en[1]), .sdata(sd[1]),
    .bclk(bc[1]), .rlclk(rl[1]), .sregr(sr[1]), .ch(chw[1]), .done(dn[1])
  );

  // Microphone model: data changes after falling bclk, frame index wraps at 16.
  always @(negedge clk) begin
    logic [31:0] cur;
    for (int g = 0; g < 2; g++) begin
      if (!reset || !en[g]) begin
        idx[g] = 0;
        fi[g]  = 0;
      end else if (pb[g] && !bc[g]) begin
        if (idx[g] == 31) begin
          idx[g] = 0;
          fi[g]  = (fi[g] + 1) % 16;
        end else begin
          idx[g] = idx[g] + 1;
        end
      end
      cur   = tx[g][fi[g]];
      sd[g] = reset ? cur[31 - idx[g]] : cyc[0];
      pb[g] = bc[g];
    end
  end

  // Record every delivered word.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (dn[g]) begin
        rxw[g][dcnt[g] % 64] = sr[g];
        rxc[g][dcnt[g] % 64] = chw[g];
        dcnt[g] = dcnt[g] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int g, input int unsigned maxc, output logic ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (dn[g]) ok = 1'b1;
    end
  endtask

  task automatic wait_left(input int g, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_done(g, 400, ok);
      if (!ok || chw[g] == 1'b0) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        ok;
    logic        any;
    int unsigned c0, c_left, n, d;
    int unsigned hi, chg, bad, rises, tog;
    logic        prl, pbc;

    for (int i = 0; i < 16; i++) begin
      tx[0][i] = {16'hA255, 16'h1234};
      tx[1][i] = $urandom;
    end

    // 1: reset with enable high, then idle
    en = 2'b11;
    ticks(10);
    check("rst_bclk", bc[0], 1'b0);
    check("rst_rlclk", rl[0], 1'b0);
    check("rst_done", dn[0], 1'b0);
    check("rst_sregr", sr[0], 16'h0000);
    check("rst_ch", chw[0], 1'b0);
    check("rst_bclk1", bc[1], 1'b0);
    reset = 1'b1;
    en    = 2'b00;
    any   = 1'b0;
    repeat (50) begin
      @(negedge clk);
      any = any | bc[0] | bc[1];
    end
    check("idle_bclk", any, 1'b0);

    // 2: first word after enable
    en[0] = 1'b1;
    c0    = cyc;
    n     = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bc[0] && n < 100);
    check("first_rise_clk", n, 4);
    wait_done(0, 2000, ok);
    check("left_done_seen", ok, 1'b1);
    check("first_done_clk", cyc - c0, 125);
    check("left_word", sr[0], 16'hA255);
    check("left_ch", chw[0], 1'b0);
    c_left = cyc;
`ifdef MIC_STEREO_EN
    wait_done(0, 400, ok);
    check("right_done_seen", ok, 1'b1);
    check("right_word", sr[0], 16'h1234);
    check("right_ch", chw[0], 1'b1);
    check("right_delay", cyc - c_left, 128);
`endif
    // 3: frame timing; in mono the next done must already be the left word
    wait_done(0, 400, ok);
    check("next_done_seen", ok, 1'b1);
    check("next_left_ch", chw[0], 1'b0);
    check("next_left_word", sr[0], 16'hA255);
    check("left_period", cyc - c_left, 256);

    hi = 0; chg = 0; bad = 0; rises = 0;
    prl = rl[0]; pbc = bc[0];
    repeat (256) begin
      @(negedge clk);
      if (rl[0]) hi++;
      if (rl[0] && bc[0] && !pbc) rises++;
      if (rl[0] != prl) begin
        chg++;
        if (!(pbc && !bc[0])) bad++;
      end
      prl = rl[0];
      pbc = bc[0];
    end
    check("rlclk_high_clk", hi, 128);
    check("rlclk_high_bclk", rises, 16);
    check("rlclk_edges", chg, 2);
    check("rlclk_on_fall", bad, 0);

    // 4: drop enable after 8 left bits, then word-complete coinciding with enable fall
    wait_left(0, ok);
    check("pre_drop_left", ok, 1'b1);
    en[0] = 1'b0;
    for (int i = 0; i < 16; i++) tx[0][i] = {16'h8001, 16'h5A5A};
    ticks(3);
    en[0] = 1'b1;
    ticks(62);
    check("bclk_high_bit8", bc[0], 1'b1);
    d = dcnt[0];
    en[0] = 1'b0;
    ticks(1);
    check("drop_bclk", bc[0], 1'b0);
    check("drop_rlclk", rl[0], 1'b0);
    ticks(300);
    check("drop_no_done", dcnt[0] - d, 0);
    check("drop_keep_sregr", sr[0], 16'hA255);
    check("drop_keep_ch", chw[0], 1'b0);
    en[0] = 1'b1;
    ticks(124);
    en[0] = 1'b0;
    ticks(1);
    check("edge_done", dn[0], 1'b1);
    check("edge_word", sr[0], 16'h8001);
    check("edge_bclk", bc[0], 1'b0);
    ticks(1);
    check("edge_done_1clk", dn[0], 1'b0);

    // 5: asynchronous reset in the middle of the right slot
    ticks(3);
    en[0] = 1'b1;
    ticks(190);
    check("mid_right_rlclk", rl[0], 1'b1);
    check("mid_right_bclk", bc[0], 1'b1);
    #1 reset = 1'b0;
    #1;
    check("async_bclk", bc[0], 1'b0);
    check("async_rlclk", rl[0], 1'b0);
    check("async_sregr", sr[0], 16'h0000);
    check("async_ch", chw[0], 1'b0);
    check("async_done", dn[0], 1'b0);
    for (int i = 0; i < 16; i++) tx[0][i] = {16'h7FFF, 16'h0F0F};
    ticks(4);
    reset = 1'b1;
    wait_done(0, 2000, ok);
    check("post_rst_seen", ok, 1'b1);
    check("post_rst_word", sr[0], 16'h7FFF);
    check("post_rst_ch", chw[0], 1'b0);
    en[0] = 1'b0;

    // 6: CLK_DIV=1, ten random frames
    ticks(2);
    en[1] = 1'b1;
    tog = 0;
    pbc = bc[1];
    repeat (645) begin
      @(negedge clk);
      if (bc[1] != pbc) tog++;
      pbc = bc[1];
    end
    en[1] = 1'b0;
    ticks(5);
    check("div1_bclk_toggles", tog, 645);
`ifdef MIC_STEREO_EN
    check("div1_done_count", dcnt[1], 20);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("div1_L%0d", k), rxw[1][2*k], tx[1][k][31:16]);
      check($sformatf("div1_Lch%0d", k), rxc[1][2*k], 1'b0);
      check($sformatf("div1_R%0d", k), rxw[1][2*k+1], tx[1][k][15:0]);
      check($sformatf("div1_Rch%0d", k), rxc[1][2*k+1], 1'b1);
    end
`else
    check("div1_done_count", dcnt[1], 10);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("div1_L%0d", k), rxw[1][k], tx[1][k][31:16]);
      check($sformatf("div1_Lch%0d", k), rxc[1][k], 1'b0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
